// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA raster generator.
//   - 640x480@60 default segment lengths (pixels / lines)
//   - sync_bundle_t: blank/hsync/vsync carried together through the pipeline
//   - axis_total(): total period of one axis from its four segments
package vga_timing_pkg;

    localparam int unsigned DEF_CNT_W     = 10;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;

    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    typedef struct packed {
        logic blank;
        logic hsync;
        logic vsync;
    } sync_bundle_t;

    function automatic int unsigned axis_total(input int unsigned visible,
                                               input int unsigned front,
                                               input int unsigned sync_len,
                                               input int unsigned back);
        return visible + front + sync_len + back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus its blank/sync decode.
// Ports:
//   clk_i    pixel clock
//   rst_i    synchronous active-high reset (count -> 0)
//   en_i     advance the count this cycle
//   count_o  current position
//   wrap_o   high in the cycle where an enabled count goes TOTAL-1 -> 0
//   blank_o  position is outside the visible segment
//   sync_o   position is inside the sync segment (active-high, raw)
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned FRONT   = DEF_H_FRONT,
    parameter int unsigned SYNC    = DEF_H_SYNC,
    parameter int unsigned BACK    = DEF_H_BACK
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             wrap_o,
    output logic             blank_o,
    output logic             sync_o
);

    localparam int unsigned      TOTAL      = axis_total(VISIBLE, FRONT, SYNC, BACK);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam int unsigned      SYNC_START = VISIBLE + FRONT;
    localparam int unsigned      SYNC_END   = SYNC_START + SYNC;

    logic [CNT_W-1:0] count_q, count_d;
    logic             at_last;
    // Widened copy so the decode compares cleanly against 32-bit boundaries,
    // including SYNC_END == 2^CNT_W when BACK is zero.
    logic [31:0]      count_ext;

    assign at_last   = (count_q == LAST);
    assign count_ext = 32'(count_q);

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = at_last ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = en_i & at_last;
    assign blank_o = (count_ext >= VISIBLE);
    assign sync_o  = (count_ext >= SYNC_START) && (count_ext < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-clock raster generator feeding the VGA-to-DVID converter.
// Two-stage output pipeline: stage 1 holds decoded sync/blank, the
// test-picture select and the pattern triple; stage 2 selects RGB and
// drives the outputs, so every vga_* output lags (x,y) by 2 cycles.
// Ports:
//   clk_pixel                 pixel clock
//   reset                     synchronous active-high; raster restarts at (0,0)
//   test_picture              1 = built-in pattern {h, v, frame}, 0 = in_*
//   x, y                      current raster position (pixel request address)
//   in_red/in_green/in_blue   source pixel for the (x,y) of the previous cycle
//   frame                     frame counter, mod 256
//   vga_r/vga_g/vga_b         video out
//   vga_hsync/vga_vsync       syncs at HSYNC_POL/VSYNC_POL when active
//   vga_blank                 1 outside the visible area
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             test_picture,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    input  logic [7:0]       in_red,
    input  logic [7:0]       in_green,
    input  logic [7:0]       in_blue,
    output logic [7:0]       frame,
    output logic [7:0]       vga_r,
    output logic [7:0]       vga_g,
    output logic [7:0]       vga_b,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic             vga_blank
);

    localparam sync_bundle_t SB_RESET = '{blank: 1'b1,
                                          hsync: ~HSYNC_POL,
                                          vsync: ~VSYNC_POL};

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_wrap, v_wrap;
    logic             h_blank, v_blank;
    logic             h_sync, v_sync;

    logic [7:0]   frame_q, frame_d;
    sync_bundle_t sb1_q, sb1_d;
    logic         tp1_q;
    logic [23:0]  pat1_q, pat1_d;
    sync_bundle_t sb2_q;
    logic [23:0]  rgb2_q, rgb2_d;

    vga_axis_counter #(
        .CNT_W   (CNT_W),
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .clk_i   (clk_pixel),
        .rst_i   (reset),
        .en_i    (1'b1),
        .count_o (h_cnt),
        .wrap_o  (h_wrap),
        .blank_o (h_blank),
        .sync_o  (h_sync)
    );

    // The vertical wrap only fires together with the horizontal wrap, so
    // v_wrap marks the last pixel of the frame.
    vga_axis_counter #(
        .CNT_W   (CNT_W),
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .clk_i   (clk_pixel),
        .rst_i   (reset),
        .en_i    (h_wrap),
        .count_o (v_cnt),
        .wrap_o  (v_wrap),
        .blank_o (v_blank),
        .sync_o  (v_sync)
    );

    always_comb begin
        frame_d = frame_q;
        if (v_wrap) begin
            frame_d = frame_q + 8'd1;
        end

        sb1_d = '{blank: h_blank | v_blank,
                  hsync: h_sync ? HSYNC_POL : ~HSYNC_POL,
                  vsync: v_sync ? VSYNC_POL : ~VSYNC_POL};

        pat1_d = {h_cnt[7:0], v_cnt[7:0], frame_q};

        // in_* arrives during stage 2 for the position now held in stage 1.
        if (sb1_q.blank) begin
            rgb2_d = '0;
        end else if (tp1_q) begin
            rgb2_d = pat1_q;
        end else begin
            rgb2_d = {in_red, in_green, in_blue};
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            frame_q <= '0;
            sb1_q   <= SB_RESET;
            tp1_q   <= 1'b0;
            pat1_q  <= '0;
            sb2_q   <= SB_RESET;
            rgb2_q  <= '0;
        end else begin
            frame_q <= frame_d;
            sb1_q   <= sb1_d;
            tp1_q   <= test_picture;
            pat1_q  <= pat1_d;
            sb2_q   <= sb1_q;
            rgb2_q  <= rgb2_d;
        end
    end

    assign x         = h_cnt;
    assign y         = v_cnt;
    assign frame     = frame_q;
    assign vga_r     = rgb2_q[23:16];
    assign vga_g     = rgb2_q[15:8];
    assign vga_b     = rgb2_q[7:0];
    assign vga_blank = sb2_q.blank;
    assign vga_hsync = sb2_q.hsync;
    assign vga_vsync = sb2_q.vsync;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. A small raster instance is fully scoreboarded
// every cycle against a cycle-index model; a default 640x480 instance is
// checked over its first two lines after each reset.
module tb_vga_timing_gen;

    localparam int HV = 12, HF = 2, HS = 6, HB = 4, HT = 24;
    localparam int VV = 4,  VF = 1, VS = 2, VB = 1, VT = 8;
    localparam int FP = HT * VT;
    localparam logic HPOL = 1'b1;
    localparam logic VPOL = 1'b0;
    localparam logic [26:0] RST_OUT = {1'b1, ~HPOL, ~VPOL, 24'h0};
    localparam int DEF_CYC = 1700;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tp = 1'b0;
    logic [9:0] x, y;
    logic [7:0] frame;
    logic [7:0] in_r = '0, in_g = '0, in_b = '0;
    logic [7:0] r, g, b;
    logic       hs, vs, bl;

    logic [9:0] dx, dy;
    logic [7:0] dframe, dr, dg, db;
    logic       dhs, dvs, dbl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CNT_W(10), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
    ) u_dut (
        .clk_pixel(clk), .reset(reset), .test_picture(tp),
        .x(x), .y(y),
        .in_red(in_r), .in_green(in_g), .in_blue(in_b),
        .frame(frame),
        .vga_r(r), .vga_g(g), .vga_b(b),
        .vga_hsync(hs), .vga_vsync(vs), .vga_blank(bl)
    );

    vga_timing_gen u_def (
        .clk_pixel(clk), .reset(reset), .test_picture(1'b1),
        .x(dx), .y(dy),
        .in_red(8'h00), .in_green(8'h00), .in_blue(8'h00),
        .frame(dframe),
        .vga_r(dr), .vga_g(dg), .vga_b(db),
        .vga_hsync(dhs), .vga_vsync(dvs), .vga_blank(dbl)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected video for the small raster, from the cycle index since restart.
    function automatic logic [26:0] model_out(input int t, input logic tpv);
        int h, v, f;
        logic blk, ha, va;
        logic [23:0] rgb;
        h = t % HT;
        v = (t / HT) % VT;
        f = (t / FP) % 256;
        blk = (h >= HV) || (v >= VV);
        ha  = (h >= HV + HF) && (h < HV + HF + HS);
        va  = (v >= VV + VF) && (v < VV + VF + VS);
        if (blk)      rgb = 24'h0;
        else if (tpv) rgb = {h[7:0], v[7:0], f[7:0]};
        else          rgb = {h[7:0], ~v[7:0], 8'hA5};
        return {blk, ha ? HPOL : ~HPOL, va ? VPOL : ~VPOL, rgb};
    endfunction

    function automatic logic [27:0] model_pos(input int t);
        return {10'(t % HT), 10'((t / HT) % VT), 8'((t / FP) % 256)};
    endfunction

    // Pixel source: one registered read of {x, ~y, A5}.
    logic [9:0] src_x = '0, src_y = '0;
    always @(negedge clk) begin
        src_x = x;
        src_y = y;
    end
    always @(posedge clk) begin
        #1;
        in_r = src_x[7:0];
        in_g = ~src_y[7:0];
        in_b = 8'hA5;
    end

    // Scoreboard: push the expectation for this cycle's position, pop it
    // two cycles later when the outputs should show it.
    logic [26:0] sb_q[$];
    int sb_t = 0;
    bit sb_on = 0;
    always @(negedge clk) begin
        logic [26:0] e;
        if (sb_on) begin
            check("pos", 64'({x, y, frame}), 64'(model_pos(sb_t)));
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("video", 64'({bl, hs, vs, r, g, b}), 64'(e));
            end
        end
        if (reset) begin
            sb_q.delete();
            sb_q.push_back(RST_OUT);
            sb_q.push_back(RST_OUT);
            sb_t  = 0;
            sb_on = 1;
        end else if (sb_on) begin
            sb_q.push_back(model_out(sb_t, tp));
            sb_t++;
        end
    end

    // Sync edge monitor on the small raster.
    int cyc = 0, ls = 0, hst = 0, vst = 0;
    bit have_ls = 0, have_h = 0, have_v = 0, ph = 0, pv = 0;
    bit mon_on = 0;
    always @(negedge clk) begin
        logic ha, va;
        ha = (hs == HPOL);
        va = (vs == VPOL);
        if (!mon_on) begin
            have_ls = 0;
            have_h  = 0;
            have_v  = 0;
        end else begin
            if (x == '0) begin
                ls = cyc;
                have_ls = 1;
            end
            if (ha && !ph) begin
                if (have_ls) check("hsync_start", 64'(cyc - ls), 64'(HV + HF + 2));
                hst = cyc;
                have_h = 1;
            end
            if (!ha && ph && have_h) check("hsync_width", 64'(cyc - hst), 64'(HS));
            if (va && !pv) begin
                if (have_v) check("frame_period", 64'(cyc - vst), 64'(FP));
                vst = cyc;
                have_v = 1;
            end
            if (!va && pv && have_v) check("vsync_width", 64'(cyc - vst), 64'(VS * HT));
        end
        ph = ha;
        pv = va;
        cyc++;
    end

    // Default-parameter instance: first DEF_CYC cycles after each reset.
    int dc = 0;
    bit dc_on = 0, rst_prev = 0;
    always @(negedge clk) begin
        int p, h, v;
        logic blk, ha;
        logic [26:0] e;
        if (dc_on && rst_prev && reset) begin
            check("def_rst_video", 64'({dbl, dhs, dvs, dr, dg, db}), 64'({1'b1, 1'b1, 1'b1, 24'h0}));
            check("def_rst_pos", 64'({dx, dy, dframe}), 64'(0));
        end else if (dc_on && !reset && dc < DEF_CYC) begin
            check("def_pos", 64'({dx, dy, dframe}), 64'({10'(dc % 800), 10'(dc / 800), 8'h00}));
            p = dc - 2;
            if (p < 0) begin
                e = {1'b1, 1'b1, 1'b1, 24'h0};
            end else begin
                h = p % 800;
                v = p / 800;
                blk = (h >= 640);
                ha  = (h >= 656) && (h < 752);
                e = {blk, ~ha, 1'b1, blk ? 24'h0 : {h[7:0], v[7:0], 8'h00}};
            end
            check("def_video", 64'({dbl, dhs, dvs, dr, dg, db}), 64'(e));
            dc++;
        end
        if (reset) begin
            dc_on = 1;
            dc = 0;
        end
        rst_prev = reset;
    end

    task automatic wait_pos(input int px, input int py, input int pf, output bit ok);
        ok = 0;
        for (int n = 0; n < 60000; n++) begin
            if (x == 10'(px) && y == 10'(py) && frame == 8'(pf)) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_pos: position (%0d,%0d) frame %0d not reached", px, py, pf);
        end
    endtask

    typedef struct {
        int f, px, py;
        logic tp;
        logic bl, hs, vs;
        logic [7:0] r, g, b;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        bit ok;
        vecs[0] = '{f:0, px:9,  py:2, tp:0, bl:0, hs:~HPOL, vs:~VPOL, r:8'h09, g:8'hFD, b:8'hA5};
        vecs[1] = '{f:0, px:5,  py:3, tp:1, bl:0, hs:~HPOL, vs:~VPOL, r:8'h05, g:8'h03, b:8'h00};
        vecs[2] = '{f:0, px:13, py:3, tp:1, bl:1, hs:~HPOL, vs:~VPOL, r:8'h00, g:8'h00, b:8'h00};
        vecs[3] = '{f:0, px:2,  py:5, tp:0, bl:1, hs:~HPOL, vs:VPOL,  r:8'h00, g:8'h00, b:8'h00};
        vecs[4] = '{f:1, px:5,  py:3, tp:1, bl:0, hs:~HPOL, vs:~VPOL, r:8'h05, g:8'h03, b:8'h01};
        vecs[5] = '{f:1, px:15, py:6, tp:1, bl:1, hs:HPOL,  vs:VPOL,  r:8'h00, g:8'h00, b:8'h00};
        vecs[6] = '{f:2, px:0,  py:0, tp:0, bl:0, hs:~HPOL, vs:~VPOL, r:8'h00, g:8'hFF, b:8'hA5};
        vecs[7] = '{f:2, px:11, py:3, tp:1, bl:0, hs:~HPOL, vs:~VPOL, r:8'h0B, g:8'h03, b:8'h02};

        // Reset held 3 cycles, then released.
        reset = 1'b1;
        tp = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        mon_on = 1;
        check("rst_video", 64'({bl, hs, vs, r, g, b}), 64'(RST_OUT));
        check("rst_pos", 64'({x, y, frame}), 64'(0));
        step();
        check("x_after_release", 64'(x), 64'(1));
        check("blank_after_release", 64'(bl), 64'(1));
        step();
        check("first_unblank", 64'(bl), 64'(0));

        // Pixel table.
        for (int i = 0; i < 8; i++) begin
            tp = vecs[i].tp;
            wait_pos(vecs[i].px, vecs[i].py, vecs[i].f, ok);
            if (ok) begin
                step();
                step();
                check($sformatf("vec%0d", i), 64'({bl, hs, vs, r, g, b}),
                      64'({vecs[i].bl, vecs[i].hs, vecs[i].vs, vecs[i].r, vecs[i].g, vecs[i].b}));
            end
        end

        // test_picture switched on exactly at pixel 6 of line 2.
        tp = 1'b0;
        wait_pos(5, 2, 3, ok);
        if (ok) begin
            step();
            tp = 1'b1;
            step();
            check("tp_edge_before", 64'({bl, hs, vs, r, g, b}), 64'({1'b0, ~HPOL, ~VPOL, 24'h05FDA5}));
            step();
            check("tp_edge_after", 64'({bl, hs, vs, r, g, b}), 64'({1'b0, ~HPOL, ~VPOL, 24'h060203}));
        end

        // Frame counter wraps 255 -> 0.
        wait_pos(HT - 1, VT - 1, 255, ok);
        if (ok) begin
            step();
            check("frame_wrap", 64'({x, y, frame}), 64'(0));
        end

        // One-cycle reset mid-frame.
        tp = 1'b0;
        wait_pos(10, 2, 1, ok);
        if (ok) begin
            mon_on = 0;
            reset = 1'b1;
            step();
            reset = 1'b0;
            mon_on = 1;
            check("midrst_pos", 64'({x, y, frame}), 64'(0));
            check("midrst_blank0", 64'(bl), 64'(1));
            step();
            check("midrst_blank1", 64'(bl), 64'(1));
            step();
            check("midrst_first_pix", 64'({bl, hs, vs, r, g, b}), 64'({1'b0, ~HPOL, ~VPOL, 24'h00FFA5}));
            repeat (2 * FP + 10) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
